rr_req_encoder: RTL and testbench
=================================

Name: rr_req_encoder

Overview:
- Round-robin request encoder; the inverse-direction companion to the netdma one-hot decoder.
- Takes a vector of 2**RANGE level-sensitive request lines (e.g. per-channel DMA pending flags) and emits a registered binary index of the granted line.
- Output uses a valid/ready handshake, so a downstream scheduler consumes one grant per transfer.
- Also emits the matching one-hot grant, so the index can be cross-checked against the decoder.

Parameters:
- RANGE, 4, width of the encoded index; number of request lines N = 2**RANGE (RANGE >= 1).

Ports:
- clk_i     input   1        system clock; all logic on rising edge.
- rst_i     input   1        synchronous, active-high reset.
- req_i     input   N        request lines; bit k high = requester k pending.
- idx_o     output  RANGE    binary index of granted requester.
- onehot_o  output  N        one-hot form of idx_o; all zeros when valid_o low.
- valid_o   output  1        idx_o/onehot_o hold a grant.
- ready_i   input   1        consumer accepts the grant; fire = valid_o & ready_i.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: valid_o=0, idx_o=0, onehot_o=0, internal priority pointer ptr=0.
  - Reset wins over every other event in the same cycle.
  - Reset asserted mid-grant drops valid_o on the next edge; no completion is owed.
- Internal pointer ptr (RANGE bits): lowest-priority-free start point of the round-robin search.
- Load condition: load = !valid_o | fire.
  - When load is low, idx_o, onehot_o and valid_o hold unchanged.
  - The grant is sticky: it holds even if the granted req_i bit drops while awaiting ready_i.
- Search base: base = fire ? (idx_o + 1) mod N : ptr. The RANGE-bit wrap is natural overflow, so N-1 wraps to 0.
- Search:
  - Scan req_i bits base, base+1, ..., base+N-1 (mod N).
  - The first set bit is the winner w.
  - Implement as a doubled-vector mask or rotate plus priority encoder; purely combinational before the output register.
- On a load edge with at least one req_i bit set: valid_o<=1, idx_o<=w, onehot_o<=(1<<w).
- On a load edge with req_i all zero: valid_o<=0, onehot_o<=0, idx_o holds its last value.
- On fire: ptr<=(idx_o+1) mod N. Otherwise ptr holds.
- Latency:
  - A request appearing while idle gives valid_o one cycle later.
  - Back-to-back grants with no bubble: with ready_i held high, a new grant is presented every cycle.
- Fairness: with all lines requesting and ready_i high, the grant sequence is ptr, ptr+1, ... cycling.
  - No requester waits more than N-1 grants.
- Single requester: the same index may be re-granted on consecutive fires.
- ready_i without valid_o has no effect.
- Invariant: onehot_o == (valid_o ? 1<<idx_o : 0) at all times after reset.
- Implementation target: 120–200 lines.

Test Plan (RANGE=2, N=4):
- Reset, then req_i=0000 for 5 cycles -> valid_o=0, onehot_o=0000, idx_o=0 throughout.
- Idle, req_i=0100 at cycle t -> valid_o=1, idx_o=2, onehot_o=0100 at t+1. Hold ready_i=0 and drop req_i to 0000 -> grant stays idx_o=2. ready_i=1 one cycle -> valid_o=0 next cycle, ptr=3.
- req_i=1111, ready_i=1 continuously from reset -> idx_o sequence 0,1,2,3,0,1 on consecutive cycles, valid_o never drops.
- ptr=3 (after the previous scenario), req_i=1001, ready_i=1 -> grants 3,0,3,0 alternating.
- req_i=0010 only, ready_i=1 -> idx_o=1 re-granted every cycle, onehot_o=0010 stable.
- Grant idx_o=1 pending, assert rst_i with ready_i=1 the same cycle -> next cycle valid_o=0, onehot_o=0000, ptr=0. Then req_i=1010 -> idx_o=1 first.

Source files
------------

// File: rtl/rr_req_encoder.sv
// rtl/rr_req_encoder.sv - round-robin request encoder with registered index, one-hot grant and valid/ready handshake
module rr_req_encoder #(
   parameter int RANGE = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [(1<<RANGE)-1:0]   req_i,
   output logic [RANGE-1:0]        idx_o,
   output logic [(1<<RANGE)-1:0]   onehot_o,
   output logic                    valid_o,
   input  logic                    ready_i
);

   localparam int N = 1 << RANGE;

   logic [RANGE-1:0] r_idx;
   logic [RANGE-1:0] r_ptr;
   logic [N-1:0]     r_onehot;
   logic             r_valid;

   logic             w_fire;
   logic             w_load;
   logic [RANGE-1:0] w_next_ptr;
   logic [RANGE-1:0] w_base;
   logic [2*N-1:0]   w_dbl;
   logic [2*N-1:0]   w_shift;
   logic [N-1:0]     w_rot;
   logic [RANGE-1:0] w_off;
   logic             w_any;
   logic [RANGE-1:0] w_win;
   logic [N-1:0]     w_win_oh;

   // Rotating a doubled copy puts the search base at bit 0, so a plain
   // lowest-set-bit encoder yields the offset of the round-robin winner.
   always_comb begin
      w_fire     = r_valid & ready_i;
      w_load     = ~r_valid | w_fire;
      w_next_ptr = r_idx + 1'b1;
      w_base     = w_fire ? w_next_ptr : r_ptr;
      w_dbl      = {req_i, req_i};
      w_shift    = w_dbl >> w_base;
      w_rot      = w_shift[N-1:0];
      w_any      = |req_i;
      w_off      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = RANGE'(k);
         end
      end
      w_win    = w_base + w_off;
      w_win_oh = {{(N-1){1'b0}}, 1'b1} << w_win;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid  <= 1'b0;
         r_idx    <= '0;
         r_onehot <= '0;
         r_ptr    <= '0;
      end else begin
         if (w_fire) begin
            r_ptr <= w_next_ptr;
         end
         if (w_load) begin
            if (w_any) begin
               r_valid  <= 1'b1;
               r_idx    <= w_win;
               r_onehot <= w_win_oh;
            end else begin
               // idx holds its last value when nothing is pending
               r_valid  <= 1'b0;
               r_onehot <= '0;
            end
         end
      end
   end

   assign idx_o    = r_idx;
   assign onehot_o = r_onehot;
   assign valid_o  = r_valid;

endmodule

// File: tb/tb_rr_req_encoder.sv
// tb/tb_rr_req_encoder.sv - directed and randomized bench for rr_req_encoder against a behavioural model
module tb_rr_req_encoder;

   localparam int RANGE = 2;
   localparam int N     = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             ready;
   logic [N-1:0]     req;
   logic [RANGE-1:0] idx;
   logic [N-1:0]     onehot;
   logic             valid;

   int n_checks = 0;
   int n_errors = 0;

   int m_valid;
   int m_idx;
   int m_ptr;

   rr_req_encoder #(.RANGE(RANGE)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .idx_o    (idx),
      .onehot_o (onehot),
      .valid_o  (valid),
      .ready_i  (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: scan requesters starting at base, wrapping modulo N.
   task automatic model_update();
      int fire;
      int base;
      int found;
      int cand;
      if (rst) begin
         m_valid = 0;
         m_idx   = 0;
         m_ptr   = 0;
      end else begin
         fire = (m_valid != 0 && ready) ? 1 : 0;
         base = fire ? (m_idx + 1) % N : m_ptr;
         if (fire) m_ptr = (m_idx + 1) % N;
         if (!m_valid || fire) begin
            found = -1;
            for (int i = 0; i < N; i++) begin
               cand = (base + i) % N;
               if (found < 0 && req[cand]) found = cand;
            end
            if (found >= 0) begin
               m_valid = 1;
               m_idx   = found;
            end else begin
               m_valid = 0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check("valid", valid, m_valid);
      check("idx", idx, m_idx);
      check("onehot", onehot, m_valid ? (1 << m_idx) : 0);
   endtask

   initial begin
      int seq3 [6];
      seq3 = '{0, 1, 2, 3, 0, 1};
      m_valid = 0;
      m_idx   = 0;
      m_ptr   = 0;
      rst   = 1'b1;
      req   = '0;
      ready = 1'b0;
      step();
      step();
      rst = 1'b0;

      repeat (5) step();
      check("s1_valid", valid, 0);
      check("s1_onehot", onehot, 0);
      check("s1_idx", idx, 0);

      req = 4'b0100;
      step();
      check("s2_idx", idx, 2);
      check("s2_onehot", onehot, 4'b0100);
      req = 4'b0000;
      step();
      check("s2_sticky_idx", idx, 2);
      check("s2_sticky_valid", valid, 1);
      ready = 1'b1;
      step();
      check("s2_drop_valid", valid, 0);

      rst = 1'b1;
      req = 4'b1111;
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("s3_seq_idx", idx, seq3[i]);
         check("s3_seq_valid", valid, 1);
      end

      rst = 1'b1;
      step();
      rst   = 1'b0;
      ready = 1'b0;
      req   = 4'b0100;
      step();
      req   = 4'b0000;
      ready = 1'b1;
      step();
      req = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         step();
         check("s4_alt_idx", idx, (i % 2 == 0) ? 3 : 0);
      end

      req = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         step();
         check("s5_single_idx", idx, 1);
         check("s5_single_onehot", onehot, 4'b0010);
      end

      rst = 1'b1;
      step();
      check("s6_rst_valid", valid, 0);
      check("s6_rst_onehot", onehot, 0);
      rst   = 1'b0;
      ready = 1'b0;
      req   = 4'b1010;
      step();
      check("s6_first_idx", idx, 1);

      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         req   = N'($urandom);
         if ($urandom_range(0, 3) == 0) req = '0;
         ready = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
